// File: rtl/adc_spi_reader_pkg.sv
// Shared definitions for the serial ADC reader.
// Holds the FSM state type, the default frame geometry and a helper that sizes
// counters. No ports.

package adc_spi_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCsSetup,
        StShift,
        StDone
    } state_e;

    // Number of bits needed to hold every value in 0..max_val (minimum one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Default frame geometry: LEAD_BITS discarded bits followed by the result.
    localparam int unsigned AdcWidthDefault = 12;
    localparam int unsigned LeadBitsDefault = 3;
    localparam int unsigned ClkDivDefault   = 4;
    localparam int unsigned FrameBitsDefault = LeadBitsDefault + AdcWidthDefault;  // N

    // Counter widths for the default geometry. The bit counter must reach N itself.
    localparam int unsigned BitCntWDefault = cnt_width(FrameBitsDefault);
    localparam int unsigned DivCntWDefault = cnt_width(ClkDivDefault - 1);

endpackage

// File: rtl/adc_spi_reader_if.sv
// Bundle of the reader's host-side handshake and ADC pin signals.
//   master : the reader (drives busy, chip select, serial clock, sample outputs)
//   slave  : the environment (drives start request and serial data from the ADC)

interface adc_spi_reader_if #(
    parameter int unsigned ADC_WIDTH = 12
) ();

    logic                 start;
    logic                 busy;
    logic                 adc_cs_n;
    logic                 adc_sclk;
    logic                 adc_miso;
    logic [ADC_WIDTH-1:0] adc_value;
    logic                 sample_valid;

    modport master (
        input  start,
        input  adc_miso,
        output busy,
        output adc_cs_n,
        output adc_sclk,
        output adc_value,
        output sample_valid
    );

    modport slave (
        output start,
        output adc_miso,
        input  busy,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_value,
        input  sample_valid
    );

endinterface

// File: rtl/adc_sclk_gen.sv
// Half-period timer and serial clock generator.
//   clk, reset : system clock, asynchronous active-low reset
//   en_i       : advance the half-period counter
//   clr_i      : force counter to 0 and serial clock low (wins over en_i)
//   toggle_i   : let the tick flip the serial clock
//   tick_o     : high in the last cycle of each half-period (counter == CLK_DIV-1)
//   sclk_o     : registered serial clock, idle low

module adc_sclk_gen
    import adc_spi_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    input  logic toggle_i,
    output logic tick_o,
    output logic sclk_o
);

    localparam int unsigned DivW = cnt_width(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            sclk_q, sclk_d;

    assign tick_o = en_i && (div_q == DivW'(CLK_DIV - 1));
    assign sclk_o = sclk_q;

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (clr_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (en_i) begin
            div_d = tick_o ? '0 : div_q + 1'b1;
            if (tick_o && toggle_i) begin
                sclk_d = ~sclk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// Serial ADC front end: runs one chip-select frame per accepted start, shifts in
// LEAD_BITS + ADC_WIDTH bits on rising serial-clock edges, drops the leading bits
// and publishes the result with a one-cycle sample_valid strobe.
//   clk, reset : system clock, asynchronous active-low reset
//   bus        : start/busy handshake, ADC pins, adc_value/sample_valid outputs

module adc_spi_reader
    import adc_spi_reader_pkg::*;
#(
    parameter int unsigned ADC_WIDTH    = 12,
    parameter int unsigned LEAD_BITS    = 3,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned CS_IDLE_HALF = 2
) (
    input logic             clk,
    input logic             reset,
    adc_spi_reader_if.master bus
);

    localparam int unsigned N        = LEAD_BITS + ADC_WIDTH;
    localparam int unsigned BitCntW  = cnt_width(N);
    localparam int unsigned IdleCntW = cnt_width(CS_IDLE_HALF);

    state_e                state_q, state_d;
    logic                  cs_n_q, cs_n_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IdleCntW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [ADC_WIDTH-1:0]  shift_q, shift_d;
    logic [ADC_WIDTH-1:0]  value_q, value_d;
    logic                  valid_q, valid_d;

    logic gen_en, gen_clr, gen_toggle;
    logic tick, sclk;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .en_i     (gen_en),
        .clr_i    (gen_clr),
        .toggle_i (gen_toggle),
        .tick_o   (tick),
        .sclk_o   (sclk)
    );

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        shift_d    = shift_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        gen_en     = 1'b0;
        gen_clr    = 1'b0;
        gen_toggle = 1'b0;

        unique case (state_q)
            StIdle: begin
                gen_clr = 1'b1;
                cs_n_d  = 1'b1;
                if (bus.start) begin
                    state_d    = StCsSetup;
                    cs_n_d     = 1'b0;
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                    shift_d    = '0;
                end
            end
            StCsSetup: begin
                gen_en = 1'b1;
                if (tick) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                gen_en     = 1'b1;
                gen_toggle = 1'b1;
                if (tick) begin
                    if (!sclk) begin
                        // Rising serial-clock edge: sample the ADC bit.
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q >= BitCntW'(LEAD_BITS)) begin
                            shift_d = {shift_q[ADC_WIDTH-2:0], bus.adc_miso};
                        end
                    end else if (bit_cnt_q == BitCntW'(N)) begin
                        // Falling edge after the last bit ends the frame.
                        state_d = StDone;
                        cs_n_d  = 1'b1;
                        value_d = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            StDone: begin
                gen_en = 1'b1;
                if (tick) begin
                    if (idle_cnt_q == IdleCntW'(CS_IDLE_HALF - 1)) begin
                        state_d = StIdle;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cs_n_q     <= 1'b1;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            shift_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shift_q    <= shift_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.adc_cs_n     = cs_n_q;
    assign bus.adc_sclk     = sclk;
    assign bus.adc_value    = value_q;
    assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: a behavioural ADC serves queued frames, a monitor
// checks timing and pops expected samples from a scoreboard queue.

module tb_adc_spi_reader;

    localparam int unsigned W        = 12;
    localparam int unsigned LEAD     = 3;
    localparam int unsigned H        = 4;
    localparam int unsigned CSI      = 2;
    localparam int unsigned N        = LEAD + W;
    localparam int          LAT      = H + 2 * H * N;          // 124
    localparam int          PERIOD   = LAT + CSI * H + 1;      // 133
    localparam int          IDLE_MIN = CSI * H;                // 8

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    adc_spi_reader_if #(.ADC_WIDTH(W)) bus ();

    logic model_miso = 1'b0;
    logic noise      = 1'b0;
    logic noise_en   = 1'b1;
    assign bus.adc_miso = noise_en ? noise : model_miso;

    adc_spi_reader #(
        .ADC_WIDTH    (W),
        .LEAD_BITS    (LEAD),
        .CLK_DIV      (H),
        .CS_IDLE_HALF (CSI)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] frame_q[$];
    int           exp_q[$];
    int           valid_cycs[$];
    int           n_valid     = 0;
    int           n_busy_fall = 0;
    int           rises       = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ADC: loads a frame when selected, presents MSB, shifts after each sclk fall.
    logic [N-1:0] cur;
    int           idx;
    bit           in_frame = 1'b0;
    initial begin
        forever begin
            @(bus.adc_cs_n or negedge bus.adc_sclk);
            if (bus.adc_cs_n !== 1'b0) begin
                in_frame   = 1'b0;
                model_miso = 1'b0;
            end else if (!in_frame) begin
                in_frame = 1'b1;
                idx      = 0;
                if (frame_q.size() > 0) cur = frame_q.pop_front();
                else cur = N'($urandom);
                model_miso = cur[N-1];
            end else begin
                idx++;
                model_miso = (idx < N) ? cur[N-1-idx] : 1'b0;
            end
        end
    end

    task automatic monitor();
        logic prev_sclk  = 1'b0;
        logic prev_cs    = 1'b1;
        logic prev_busy  = 1'b0;
        int   run        = 0;
        int   cs_hi      = 0;
        int   accept_cyc = 0;
        int   e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                prev_sclk = 1'b0;
                prev_cs   = 1'b1;
                prev_busy = 1'b0;
                run       = 0;
                cs_hi     = 0;
                rises     = 0;
            end else begin
                if (bus.adc_sclk !== prev_sclk) begin
                    if (prev_sclk) begin
                        check(run == H, "sclk_high_half", run, H);
                    end else begin
                        if (rises > 0) check(run == H, "sclk_low_half", run, H);
                        rises++;
                    end
                    run = 1;
                end else begin
                    run++;
                end

                if (prev_cs && !bus.adc_cs_n) begin
                    check(cs_hi >= IDLE_MIN, "cs_deselect_time", cs_hi, IDLE_MIN);
                    accept_cyc = cyc;
                    rises      = 0;
                end
                cs_hi = bus.adc_cs_n ? cs_hi + 1 : 0;

                if (bus.sample_valid) begin
                    n_valid++;
                    valid_cycs.push_back(cyc);
                    check(cyc - accept_cyc == LAT, "valid_latency", cyc - accept_cyc, LAT);
                    check(rises == N, "sclk_rises", rises, N);
                    check(exp_q.size() > 0, "sample_expected", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check(int'(bus.adc_value) == e, "adc_value", bus.adc_value, e);
                    end
                end

                if (prev_busy && !bus.busy) n_busy_fall++;
                prev_sclk = bus.adc_sclk;
                prev_cs   = bus.adc_cs_n;
                prev_busy = bus.busy;
            end
        end
    endtask

    task automatic push_frame(input logic [LEAD-1:0] lead, input logic [W-1:0] val);
        frame_q.push_back({lead, val});
        exp_q.push_back(int'(val));
    endtask

    // Issue a one-cycle start while idle and confirm it was accepted.
    task automatic start_frame(input logic [LEAD-1:0] lead, input logic [W-1:0] val);
        push_frame(lead, val);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        check(bus.adc_cs_n == 1'b0, "accept_cs_n", bus.adc_cs_n, 0);
        check(bus.busy == 1'b1, "accept_busy", bus.busy, 1);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(!bus.busy, "frame_timeout", k, 400);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0]    rv;
        logic [LEAD-1:0] rl;
        int base, vbase, bf, k;

        bus.start = 1'b0;
        fork
            monitor();
        join_none

        // Reset with serial data wiggling.
        repeat (3) begin
            @(negedge clk);
            noise = ~noise;
        end
        check(bus.adc_cs_n == 1'b1, "reset_cs_n", bus.adc_cs_n, 1);
        check(bus.adc_sclk == 1'b0, "reset_sclk", bus.adc_sclk, 0);
        check(bus.adc_value == '0, "reset_value", bus.adc_value, 0);
        check(bus.sample_valid == 1'b0, "reset_valid", bus.sample_valid, 0);
        check(bus.busy == 1'b0, "reset_busy", bus.busy, 0);
        reset    = 1'b1;
        noise_en = 1'b0;
        repeat (12) @(negedge clk);

        // Single frame.
        start_frame(3'b110, 12'd2000);
        wait_idle();

        // Boundary values with all lead bits set, then random frames.
        start_frame(3'b111, 12'h000);
        wait_idle();
        start_frame(3'b111, 12'hFFF);
        wait_idle();
        start_frame(3'b111, 12'h800);
        wait_idle();
        repeat (4) begin
            rv = W'($urandom);
            rl = LEAD'($urandom);
            start_frame(rl, rv);
            wait_idle();
        end

        // Continuous: start held high for three frames.
        push_frame(3'b110, 12'd4000);
        push_frame(3'b110, 12'd500);
        push_frame(3'b110, 12'd3000);
        base  = n_valid;
        vbase = valid_cycs.size();
        @(negedge clk);
        bus.start = 1'b1;
        k = 0;
        while (n_valid < base + 3 && k < 3 * PERIOD + 100) begin
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check(n_valid == base + 3, "continuous_count", n_valid - base, 3);
        if (valid_cycs.size() >= vbase + 3) begin
            check(valid_cycs[vbase+1] - valid_cycs[vbase] == PERIOD, "period_1",
                  valid_cycs[vbase+1] - valid_cycs[vbase], PERIOD);
            check(valid_cycs[vbase+2] - valid_cycs[vbase+1] == PERIOD, "period_2",
                  valid_cycs[vbase+2] - valid_cycs[vbase+1], PERIOD);
        end
        wait_idle();

        // Start during a frame is ignored.
        base = n_valid;
        bf   = n_busy_fall;
        rv   = W'($urandom);
        start_frame(3'b110, rv);
        repeat (49) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check(n_valid == base + 1, "ignored_start_samples", n_valid - base, 1);
        check(n_busy_fall == bf + 1, "ignored_start_busy_falls", n_busy_fall - bf, 1);
        check(bus.busy == 1'b0, "ignored_start_idle", bus.busy, 0);

        // Reset asserted while sclk is high during bit 7.
        base = n_valid;
        rv   = W'($urandom);
        start_frame(3'b110, rv);
        k = 0;
        while (!(rises >= 7 && bus.adc_sclk) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(bus.adc_sclk == 1'b1, "midframe_reach", bus.adc_sclk, 1);
        #2;
        reset = 1'b0;
        #1;
        check(bus.adc_cs_n == 1'b1, "async_reset_cs_n", bus.adc_cs_n, 1);
        check(bus.adc_sclk == 1'b0, "async_reset_sclk", bus.adc_sclk, 0);
        check(bus.adc_value == '0, "async_reset_value", bus.adc_value, 0);
        check(bus.busy == 1'b0, "async_reset_busy", bus.busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check(n_valid == base, "no_sample_after_reset", n_valid - base, 0);
        rv = W'($urandom);
        start_frame(3'b101, rv);
        wait_idle();

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "pending_samples", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- SPI-style serial ADC front end that produces the parallel `adc_value` samples consumed by the voltage monitor.
- Drives chip-select and serial clock to an external read-only ADC (MCP3201-class) and shifts in one conversion frame.
- Strips the leading bits of the frame and presents a registered `ADC_WIDTH`-bit sample with a one-cycle valid strobe.
- Sits between the board ADC pins and the threshold/monitoring logic.

Parameters:
- `ADC_WIDTH`, 12, bits of conversion result, MSB first on the wire.
- `LEAD_BITS`, 3, frame bits clocked before the result MSB (sample/null bits); discarded.
- `CLK_DIV`, 4, system clocks per `adc_sclk` half-period (H); must be >= 1.
- `CS_IDLE_HALF`, 2, `adc_sclk` half-periods `adc_cs_n` is held high after a frame (min deselect time).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until return to IDLE.
- `adc_cs_n`  out  1  ADC chip select, active low, registered.
- `adc_sclk`  out  1  ADC serial clock, idle low, registered.
- `adc_miso`  in  1  ADC serial data; changes after `adc_sclk` falls.
- `adc_value`  out  `ADC_WIDTH`  last complete conversion result.
- `sample_valid`  out  1  one-cycle pulse when `adc_value` updates.

Behaviour:
- Reset (`reset` = 0, any time, including mid-frame):
  - state IDLE, `adc_cs_n` = 1, `adc_sclk` = 0, `busy` = 0, `sample_valid` = 0, `adc_value` = 0.
  - Shift register and counters clear; no partial result is ever published.
- Definitions: N = `LEAD_BITS` + `ADC_WIDTH` (15 by default). One half-period counter counts 0..H-1 and emits a tick on H-1.
- IDLE:
  - `adc_cs_n` = 1, `adc_sclk` = 0.
  - `start` = 1 at an edge -> CS_SETUP; `adc_cs_n` goes 0 and `busy` goes 1 on that edge.
- CS_SETUP:
  - H cycles with `adc_cs_n` low, `adc_sclk` low.
  - Tick -> SHIFT.
- SHIFT: N bit periods of 2H cycles each.
  - Each bit: `adc_sclk` low H cycles, then high H cycles.
  - `adc_miso` is captured at the clk edge where `adc_sclk` goes 0->1.
  - A bit counter counts captured bits. The first `LEAD_BITS` captures are discarded; the remaining `ADC_WIDTH` shift in MSB first.
  - After the N-th high half-period, `adc_sclk` returns to 0 and the state goes to DONE on the same edge. SHIFT lasts exactly 2HN cycles.
- DONE entry edge:
  - `adc_value` <= assembled word; `sample_valid` = 1 for that one cycle; `adc_cs_n` <= 1.
  - Latency: `sample_valid` is high in the cycle beginning H + 2HN edges after the accepting edge (124 with defaults).
- DONE:
  - Hold `adc_cs_n` high for `CS_IDLE_HALF`·H cycles, then IDLE; `busy` drops on entry to IDLE.
- `start` while `busy` is ignored (not queued).
- `start` held high gives back-to-back frames with period H + 2HN + `CS_IDLE_HALF`·H + 1 cycles (133 with defaults).
- `adc_value` holds its value between frames and is never partially updated.
- Counters are sized with `$clog2`. The bit counter must reach N without overflow for `ADC_WIDTH` up to 16.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CS_SETUP, SHIFT, DONE);
  - localparam N = `LEAD_BITS` + `ADC_WIDTH`;
  - counter-width localparams.
- One sub-module, `adc_sclk_gen`: the half-period counter, producing the tick and the registered `adc_sclk` toggle, with enable and clear from the FSM.
- FSM and shift register stay in `adc_spi_reader`.

Test Plan:
- Reset: hold `reset` = 0 for 3 cycles with `adc_miso` toggling -> `adc_cs_n` = 1, `adc_sclk` = 0, `adc_value` = 0, `sample_valid` = 0, `busy` = 0.
- Single frame: behavioural ADC model serves value 12'd2000 (lead bits 1,1,0), pulse `start` once.
  - Required: `sample_valid` exactly 124 cycles after the accepting edge.
  - Required: `adc_value` = 2000, exactly 15 `adc_sclk` rising edges, each `adc_sclk` half-period 4 cycles.
- Boundary values: frames serving 12'h000, 12'hFFF, 12'h800 -> `adc_value` matches each; lead bits set to 1,1,1 are still discarded.
- Continuous: `start` tied high, model serves 4000, 500, 3000 -> three `sample_valid` pulses 133 cycles apart, values in order; `adc_cs_n` high for 8 cycles between frames.
- Ignored start: pulse `start` at cycle 50 of a frame -> no extra frame; `busy` falls once; only one `sample_valid`.
- Reset mid-frame: drive `reset` low during bit 7 of a frame -> `adc_cs_n` = 1 and `adc_sclk` = 0 immediately (asynchronous), `adc_value` = 0, no `sample_valid`. A following `start` produces a correct full frame.
